scalar_vec_sequencer: RTL and testbench

// - Computes the RLS scalar-times-vector update y = a*b (Q16.16) on a bank of COMBSIZE shared multiplier lanes.
// - The lanes are time-multiplexed over the SIZE-element vector, one COMBSIZE-element chunk per clock.
// - Sits between the RLS control FSM (start/done handshake) and the gain/P-update datapath, which consumes y.

---
 rtl/scalar_vec_sequencer_pkg.sv | 23 ++
 rtl/scalar_vec_sequencer_q16_mul_lane.sv | 50 +++++
 rtl/scalar_vec_sequencer.sv | 121 ++++++++++++
 tb/tb_scalar_vec_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/scalar_vec_sequencer_pkg.sv
// Shared fixed-point constants, FSM encoding and sizing helper
// for the RLS scalar-times-vector sequencer.
package scalar_vec_sequencer_pkg;

    localparam int RLS_WIDTH = 32;
    localparam int RLS_FRAC  = 16;

    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;
    localparam logic [31:0] Q_ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scalar_vec_sequencer_q16_mul_lane.sv
// q16_mul_lane: one combinational signed Q16.16 multiply lane.
// Ports: a, b (operands), y (product slice). Macro: SVS_SATURATE_EN.
module q16_mul_lane
    import scalar_vec_sequencer_pkg::*;
#(
    parameter int WIDTH = RLS_WIDTH,
    parameter int FRAC  = RLS_FRAC
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    logic signed [2*WIDTH-1:0] p;

    // Sign-extend first so the full-width product is exact.
    assign ax = {{WIDTH{a[WIDTH-1]}}, a};
    assign bx = {{WIDTH{b[WIDTH-1]}}, b};
    assign p  = ax * bx;

`ifdef SVS_SATURATE_EN
    logic [WIDTH-FRAC:0] hi;
    logic                ovf;

    // Bits above the kept slice plus its sign bit must agree.
    assign hi  = p[2*WIDTH-1:WIDTH+FRAC-1];
    assign ovf = !((&hi) || !(|hi));

    always_comb begin
        if (!ovf) begin
            y = p[WIDTH+FRAC-1:FRAC];
        end else if (p[2*WIDTH-1]) begin
            y = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            y = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    logic unused_lsb;
    assign unused_lsb = ^p[FRAC-1:0];
`else
    assign y = p[WIDTH+FRAC-1:FRAC];

    logic unused_bits;
    assign unused_bits = ^{p[2*WIDTH-1:WIDTH+FRAC], p[FRAC-1:0]};
`endif

endmodule

// File: rtl/scalar_vec_sequencer.sv
// scalar_vec_sequencer: y = a*b over SIZE_B elements, COMBSIZE lanes/clk.
// Ports: clk, reset, start/busy/done, a, b, y, chunk. Macro: SVS_SATURATE_EN.
module scalar_vec_sequencer
    import scalar_vec_sequencer_pkg::*;
#(
    parameter  int WIDTH    = RLS_WIDTH,
    parameter  int SIZE_B   = 16,
    parameter  int COMBSIZE = 4,
    parameter  int FRAC     = RLS_FRAC,
    localparam int NCHUNK   = SIZE_B / COMBSIZE,
    localparam int CW       = cw(NCHUNK)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH*SIZE_B-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH*SIZE_B-1:0] y,
    output logic [CW-1:0]           chunk
);

    if (SIZE_B % COMBSIZE != 0) begin : g_cfg_err
        $error("SIZE_B must be a multiple of COMBSIZE");
    end

    localparam int IW = cw(SIZE_B);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    chunk_q;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r [SIZE_B];
    logic [WIDTH-1:0] y_q [SIZE_B];
    logic [IW-1:0]    lidx [COMBSIZE];
    logic [WIDTH-1:0] lb [COMBSIZE];
    logic [WIDTH-1:0] ly [COMBSIZE];
    logic             accept;
    logic             last;

    assign accept = (state_q == S_IDLE) && start;
    assign last   = (chunk_q == CW'(NCHUNK - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        chunk = '0;
        case (state_q)
            S_RUN: begin
                busy  = 1'b1;
                chunk = chunk_q;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Each lane l handles element chunk*COMBSIZE + l.
    for (genvar l = 0; l < COMBSIZE; l++) begin : g_lane
        assign lidx[l] = IW'(int'(chunk_q) * COMBSIZE + l);
        assign lb[l]   = b_r[lidx[l]];

        q16_mul_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
        ) u_lane (
            .a (a_r),
            .b (lb[l]),
            .y (ly[l])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r     <= '0;
            chunk_q <= '0;
            for (int i = 0; i < SIZE_B; i++) begin
                b_r[i] <= '0;
                y_q[i] <= '0;
            end
        end else if (accept) begin
            a_r     <= a;
            chunk_q <= '0;
            for (int i = 0; i < SIZE_B; i++) begin
                b_r[i] <= b[WIDTH*i +: WIDTH];
            end
        end else if (state_q == S_RUN) begin
            for (int l = 0; l < COMBSIZE; l++) begin
                y_q[lidx[l]] <= ly[l];
            end
            chunk_q <= last ? '0 : chunk_q + 1'b1;
        end
    end

    for (genvar i = 0; i < SIZE_B; i++) begin : g_out
        assign y[WIDTH*i +: WIDTH] = y_q[i];
    end

endmodule

// File: tb/tb_scalar_vec_sequencer.sv
// Scoreboard bench for scalar_vec_sequencer (COMBSIZE 4 and 16).
// Directed vectors with hand-derived expectations.
module tb_scalar_vec_sequencer;
    import scalar_vec_sequencer_pkg::*;

    localparam int NCH = 4;

    typedef struct {
        logic [511:0] y;
        int           edge_n;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         start16;
    logic [31:0]  a;
    logic [511:0] b;
    logic         busy, done, busy16, done16;
    logic [511:0] y, y16;
    logic [1:0]   chunk;
    logic [0:0]   chunk16;

    exp_t q[$];
    exp_t q16[$];
    exp_t me;
    int   n_chk = 0;
    int   n_fail = 0;
    int   ecount = 0;

    scalar_vec_sequencer #(
        .WIDTH(32), .SIZE_B(16), .COMBSIZE(4), .FRAC(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .a(a), .b(b), .busy(busy), .done(done),
        .y(y), .chunk(chunk)
    );

    scalar_vec_sequencer #(
        .WIDTH(32), .SIZE_B(16), .COMBSIZE(16), .FRAC(16)
    ) dut16 (
        .clk(clk), .reset(reset), .start(start16),
        .a(a), .b(b), .busy(busy16), .done(done16),
        .y(y16), .chunk(chunk16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string nm,
                         input logic [511:0] act,
                         input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] av,
                         input logic [511:0] bv,
                         input logic [511:0] yv,
                         input bit also16,
                         input bit push);
        a = av;
        b = bv;
        start = 1'b1;
        start16 = also16;
        if (push) q.push_back('{y: yv, edge_n: ecount + 1 + NCH});
        if (also16) q16.push_back('{y: yv, edge_n: ecount + 2});
        @(negedge clk);
        start = 1'b0;
        start16 = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (q.size() == 0 && q16.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        if (q.size() != 0 || q16.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d/%0d want 0",
                     q.size(), q16.size());
        end
        @(negedge clk);
    endtask

    task automatic monitor_step();
        if (!reset && done) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: edge %0d", ecount);
            end else begin
                me = q.pop_front();
                check("done_edge", 512'(ecount), 512'(me.edge_n));
                check("busy_at_done", 512'(busy), 512'd1);
                for (int i = 0; i < 16; i++)
                    check($sformatf("y[%0d]", i),
                          512'(y[32*i +: 32]), 512'(me.y[32*i +: 32]));
            end
        end
        if (!reset && done16) begin
            if (q16.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done16: edge %0d", ecount);
            end else begin
                me = q16.pop_front();
                check("done16_edge", 512'(ecount), 512'(me.edge_n));
                for (int i = 0; i < 16; i++)
                    check($sformatf("y16[%0d]", i),
                          512'(y16[32*i +: 32]), 512'(me.y[32*i +: 32]));
            end
        end
        if (!reset && busy16)
            check("chunk16", 512'(chunk16), 512'd0);
    endtask

    task automatic stimulus();
        logic [511:0] bv, yv, bv2, bv3, yv2, yv3;
        int bc, bc16;
        int exp_chunk [8];
        exp_chunk = '{0, 1, 2, 3, 0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; start16 = 1'b0;
        a = '0; b = '0;
        #2;
        check("rst_busy", 512'(busy), 512'd0);
        check("rst_done", 512'(done), 512'd0);
        check("rst_y", y, 512'd0);
        check("rst_chunk", 512'(chunk), 512'd0);
        check("rst_y16", y16, 512'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Test 1 + COMBSIZE=16 build: a=1.0, b[i]=i.0
        for (int i = 0; i < 16; i++) begin
            bv[32*i +: 32] = 32'(i) << 16;
            yv[32*i +: 32] = 32'(i) << 16;
        end
        issue(Q_ONE, bv, yv, 1'b1, 1'b1);
        bc = 0; bc16 = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy) bc++;
            if (busy16) bc16++;
            check($sformatf("t1_chunk_c%0d", k + 1),
                  512'(chunk), 512'(exp_chunk[k]));
            @(negedge clk);
        end
        check("t1_busy_cycles", 512'(bc), 512'd5);
        check("t1_busy16_cycles", 512'(bc16), 512'd2);
        drain();

        // Test 2: a=-0.5
        for (int i = 0; i < 16; i++)
            yv[32*i +: 32] = 32'(-(i * 32768));
        issue(32'hFFFF_8000, bv, yv, 1'b0, 1'b1);
        drain();

        // Test 3: 256.0 * 200.0 overflows Q16.16
        bv = '0;
        yv = '0;
        bv[32*15 +: 32] = 32'h00C8_0000;
`ifdef SVS_SATURATE_EN
        yv[32*15 +: 32] = Q_MAX;
`else
        yv[32*15 +: 32] = 32'hC800_0000;
`endif
        issue(32'h0100_0000, bv, yv, 1'b0, 1'b1);
        drain();

        // Test 4: start held, b changed mid-RUN
        for (int i = 0; i < 16; i++) begin
            bv[32*i +: 32]  = 32'(i) << 16;
            bv2[32*i +: 32] = 32'(i + 1) << 16;
            bv3[32*i +: 32] = 32'(-i) << 16;
            yv[32*i +: 32]  = 32'(i) << 17;
            yv2[32*i +: 32] = 32'(i + 1) << 17;
            yv3[32*i +: 32] = 32'(-(i * 131072));
        end
        a = 32'h0002_0000;
        b = bv;
        start = 1'b1;
        q.push_back('{y: yv,  edge_n: ecount + 1 + NCH});
        q.push_back('{y: yv2, edge_n: ecount + 7 + NCH});
        q.push_back('{y: yv3, edge_n: ecount + 13 + NCH});
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 2) b = bv2;
            if (k == 8) b = bv3;
        end
        start = 1'b0;
        drain();

        // Test 5: async reset at chunk 2
        for (int i = 0; i < 16; i++) begin
            bv[32*i +: 32] = 32'(i) << 16;
            yv[32*i +: 32] = 32'(i) << 16;
        end
        issue(Q_ONE, bv, yv, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t5_chunk_pre", 512'(chunk), 512'd2);
        #1 reset = 1'b1;
        #1;
        check("t5_busy", 512'(busy), 512'd0);
        check("t5_done", 512'(done), 512'd0);
        check("t5_y", y, 512'd0);
        check("t5_chunk", 512'(chunk), 512'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(Q_ONE, bv, yv, 1'b0, 1'b1);
        drain();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            stimulus();
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
